multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-bit rising-edge detector. Each channel synchronises its raw input (button/switch), debounces it, and emits one-cycle rise/fall pulses. A mode input selects which edge kinds reach `outedge`. A saturating counter tallies every qualified edge across all channels. The block sits between board push-buttons/switches and the lab FSMs/counters that need clean single-cycle strobes.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised value must differ from the stable level before it is accepted (>=1)
CNT_WIDTH, 8, width of the aggregate edge counter (>=1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
signal  input  CHANNELS  raw asynchronous inputs, bit i = channel i
mode  input  2  edge select: 00 rising, 01 falling, 10 both, 11 none
clear_count  input  1  synchronous clear of edge_count
level  output  CHANNELS  debounced stable level per channel
rise_pulse  output  CHANNELS  one-cycle pulse when level goes 0->1
fall_pulse  output  CHANNELS  one-cycle pulse when level goes 1->0
outedge  output  CHANNELS  mode-qualified edge pulse per channel
edge_count  output  CNT_WIDTH  saturating total of qualified edges

Behaviour:
- Reset: with rst high at a clock edge, all synchroniser flops, level, debounce counters, rise_pulse, fall_pulse and edge_count are cleared to 0. outedge is therefore 0. rst overrides every other input. A debounce in progress is discarded.
- Synchroniser: per channel, a SYNC_STAGES-deep flop chain. `sync` is the last stage.
- Debounce, per channel:
  - State is the stable `level` plus a counter `dcnt` of width clog2(DEBOUNCE_CYCLES)+1.
  - If sync == level: dcnt <= 0.
  - If sync != level and dcnt == DEBOUNCE_CYCLES-1: level <= sync and dcnt <= 0.
  - Otherwise: dcnt <= dcnt+1.
  - Any bounce back to the old level before acceptance restarts the count. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- Latency: number edges from 0, where edge 0 is the first clk edge that samples the new signal value. level changes, and the pulse asserts, after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is edge 5, so the output is visible during the 6th cycle.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and are high for exactly the one cycle after the edge at which level[i] changed.
  - They are never both high together.
  - They are 0 in all other cycles.
- outedge (combinational from registered pulses and mode):
  - 00: outedge = rise_pulse
  - 01: outedge = fall_pulse
  - 10: outedge = rise_pulse | fall_pulse
  - 11: outedge = 0
  - A mode change takes effect in the same cycle. Pulses already registered are qualified by the current mode.
- edge_count:
  - Each clock, edge_count <= min(edge_count + popcount(outedge), 2^CNT_WIDTH-1).
  - Use a CNT_WIDTH+clog2(CHANNELS)+1 wide intermediate so the sum never wraps. The counter saturates and holds.
  - clear_count has priority: edge_count <= 0, and edges qualified in that cycle are dropped.
- Channels are fully independent. Simultaneous edges on any subset are all reported and all counted in the same cycle.

Test Plan:
1. Defaults, mode=00; signal[0] goes 0->1 cleanly. -> level[0] and rise_pulse[0] go high after edge 5, rise_pulse[0] lasts 1 cycle, outedge[0] pulses once, edge_count=1. Other channels stay 0.
2. Glitch on signal[1]: high for 3 cycles, then low. -> no level change, no pulses, edge_count unchanged. A following 6-cycle high is accepted, giving 1 rise.
3. mode=10; signal[2] toggles 0->1->0, each level held for 10 cycles. -> rise_pulse then fall_pulse, edge_count=2. Repeat with mode=11 -> pulses still appear, outedge=0, count unchanged.
4. All 4 channels rise on the same cycle, mode=00. -> rise_pulse=4'b1111 in one cycle, edge_count += 4. With CNT_WIDTH=3 and a starting count of 6, edge_count=7 and stays 7 on further edges.
5. rst asserted at debounce count 2 on channel 3, with signal held high. -> all outputs are 0 next cycle. Channel 3 re-qualifies with full latency (edge 5 counted from the first post-reset sampling edge).
6. clear_count asserted in the same cycle outedge[0]=1 and edge_count=5. -> edge_count=0 next cycle, that edge is not counted. The next edge gives 1.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser, debouncer and rise/fall pulse generator, with a
// mode-qualified edge output and a saturating aggregate edge counter.
module multi_edge_detector #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CHANNELS-1:0]  signal,
   input  logic [1:0]           mode,
   input  logic                 clear_count,
   output logic [CHANNELS-1:0]  level,
   output logic [CHANNELS-1:0]  rise_pulse,
   output logic [CHANNELS-1:0]  fall_pulse,
   output logic [CHANNELS-1:0]  outedge,
   output logic [CNT_WIDTH-1:0] edge_count
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int SW = CNT_WIDTH + $clog2(CHANNELS) + 1;
   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] CMAX  = SW'({CNT_WIDTH{1'b1}});

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
   logic [CHANNELS-1:0][DW-1:0]          dcnt_q, dcnt_d;
   logic [CHANNELS-1:0]                  level_q, level_d;
   logic [CHANNELS-1:0]                  rise_q, rise_d;
   logic [CHANNELS-1:0]                  fall_q, fall_d;
   logic [CNT_WIDTH-1:0]                 count_q, count_d;
   logic [CHANNELS-1:0]                  sync;
   logic [SW-1:0]                        sum;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = signal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Any cycle where sync matches the stable level restarts the qualification.
   always_comb begin
      level_d = level_q;
      dcnt_d  = dcnt_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (sync[c] == level_q[c]) begin
            dcnt_d[c] = '0;
         end else if (dcnt_q[c] == DLAST) begin
            level_d[c] = sync[c];
            dcnt_d[c]  = '0;
         end else begin
            dcnt_d[c] = dcnt_q[c] + DW'(1);
         end
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end

   always_comb begin
      outedge = '0;
      case (mode)
         2'b00:   outedge = rise_q;
         2'b01:   outedge = fall_q;
         2'b10:   outedge = rise_q | fall_q;
         default: outedge = '0;
      endcase
   end

   // Wide sum so adding every channel's edge to a full counter cannot wrap.
   always_comb begin
      sum = SW'(count_q);
      for (int c = 0; c < CHANNELS; c++) begin
         sum = sum + SW'(outedge[c]);
      end
      if (clear_count) begin
         count_d = '0;
      end else if (sum > CMAX) begin
         count_d = '1;
      end else begin
         count_d = sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         dcnt_q  <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         count_q <= '0;
      end else begin
         sync_q  <= sync_d;
         dcnt_q  <= dcnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign edge_count = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised bench for multi_edge_detector against a delay-line plus
// run-length reference model; small counter width so saturation is reached.
module tb_multi_edge_detector;
   localparam int CH    = 4;
   localparam int SS    = 2;
   localparam int DB    = 4;
   localparam int CW    = 4;
   localparam int CMAXV = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] signal;
   logic [1:0]    mode;
   logic          clear_count;
   logic [CH-1:0] level, rise_pulse, fall_pulse, outedge;
   logic [CW-1:0] edge_count;

   always #5 clk = ~clk;

   multi_edge_detector #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .signal(signal), .mode(mode),
      .clear_count(clear_count), .level(level), .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse), .outedge(outedge), .edge_count(edge_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raw samples travel through an SS-deep delay line; a
   // channel flips after DB consecutive delayed samples disagree with it.
   bit pipe[CH][$];
   bit m_level[CH];
   bit m_rise[CH];
   bit m_fall[CH];
   int m_run[CH];
   int m_count;
   int hold[CH];

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         pipe[c] = {};
         repeat (SS) pipe[c].push_back(1'b0);
         m_level[c] = 1'b0;
         m_rise[c]  = 1'b0;
         m_fall[c]  = 1'b0;
         m_run[c]   = 0;
      end
      m_count = 0;
   endtask

   function automatic logic [CH-1:0] exp_edges(input logic [1:0] md);
      logic [CH-1:0] v;
      v = '0;
      for (int c = 0; c < CH; c++) begin
         v[c] = (m_rise[c] && (md == 2'd0 || md == 2'd2)) ||
                (m_fall[c] && (md == 2'd1 || md == 2'd2));
      end
      return v;
   endfunction

   task automatic model_step();
      int n;
      bit seen;
      if (rst) begin
         model_reset();
         return;
      end
      n = $countones(exp_edges(mode));
      if (clear_count) m_count = 0;
      else m_count = (m_count + n > CMAXV) ? CMAXV : m_count + n;
      for (int c = 0; c < CH; c++) begin
         seen = pipe[c].pop_front();
         pipe[c].push_back(signal[c]);
         m_rise[c] = 1'b0;
         m_fall[c] = 1'b0;
         if (seen == m_level[c]) begin
            m_run[c] = 0;
         end else begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               m_level[c] = seen;
               m_run[c]   = 0;
               m_rise[c]  = seen;
               m_fall[c]  = !seen;
            end
         end
      end
   endtask

   task automatic check_all(input string phase);
      logic [CH-1:0] lv, rv, fv;
      for (int c = 0; c < CH; c++) begin
         lv[c] = m_level[c];
         rv[c] = m_rise[c];
         fv[c] = m_fall[c];
      end
      chk({phase, "_level"}, 32'(level), 32'(lv));
      chk({phase, "_rise"}, 32'(rise_pulse), 32'(rv));
      chk({phase, "_fall"}, 32'(fall_pulse), 32'(fv));
      chk({phase, "_outedge"}, 32'(outedge), 32'(exp_edges(mode)));
      chk({phase, "_edge_count"}, 32'(edge_count), 32'(m_count));
      chk({phase, "_rise_fall_excl"}, 32'(rise_pulse & fall_pulse), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      signal      = '0;
      mode        = 2'b00;
      clear_count = 1'b0;
      model_reset();
      for (int c = 0; c < CH; c++) hold[c] = 1;
      repeat (3) @(posedge clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         check_all(cyc == 0 ? "reset" : "run");

         rst         = ($urandom_range(0, 399) == 0);
         clear_count = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) begin
            signal = ~signal;
            for (int c = 0; c < CH; c++) hold[c] = $urandom_range(DB + 3, 12);
         end else begin
            for (int c = 0; c < CH; c++) begin
               hold[c]--;
               if (hold[c] <= 0) begin
                  signal[c] = ~signal[c];
                  hold[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DB + 1)
                                                        : $urandom_range(DB + 3, 12);
               end
            end
         end

         #1;
         chk("outedge_mode_now", 32'(outedge), 32'(exp_edges(mode)));
         model_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
